// File: rtl/main_slave_session_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : main_slave_session_sequencer_if
// Purpose  : Bundles the three handshake groups of the session sequencer:
//            the input byte stream, the slave RAM port of the accelerator and
//            the readback byte stream.
// Modports : master - sequencer side (accepts input bytes, drives S_*,
//                     produces readback bytes)
//            slave  - environment side (byte source, RAM slave, byte sink)
// Revision : 1.0 - initial release
// ============================================================================
interface main_slave_session_sequencer_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);
  // input byte stream
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  // accelerator slave RAM port (channel 0 only)
  logic [1:0]        S_oe_ram;
  logic [1:0]        S_we_ram;
  logic [ADDR_W-1:0] S_addr_ram;
  logic [DATA_W-1:0] S_Wdata_ram;
  logic [7:0]        S_data_ram_size;
  logic [DATA_W-1:0] Sout_Rdata_ram;
  logic [1:0]        Sout_DataRdy;
  // readback byte stream
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_last;
  logic              out_ready;

  modport master (
    input  in_valid, in_data, in_last,
    output in_ready,
    output S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
    input  Sout_Rdata_ram, Sout_DataRdy,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    output in_valid, in_data, in_last,
    input  in_ready,
    input  S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
    output Sout_Rdata_ram, Sout_DataRdy,
    input  out_valid, out_data, out_last,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/main_slave_session_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : main_slave_session_sequencer
// Purpose  : Runs one session of the HLS `main` accelerator through its slave
//            RAM port: streams input bytes into accelerator memory, pulses
//            start_port, counts cycles until done_port (with abort after
//            TIMEOUT cycles), then reads a result window back as bytes.
// Ports    : clock, reset (async, active low)
//            go / load_base / rd_base / rd_len - session control, latched on go
//            bus (master modport) - input stream, slave RAM, readback stream
//            start_port / done_port - accelerator control
//            cycle_count / busy / finished / timeout - session status
// Revision : 1.0 - initial release
// ============================================================================
module main_slave_session_sequencer #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 16,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 200000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                go,
  input  logic [ADDR_W-1:0]   load_base,
  input  logic [ADDR_W-1:0]   rd_base,
  input  logic [ADDR_W-1:0]   rd_len,
  main_slave_session_sequencer_if.master bus,
  output logic                start_port,
  input  logic                done_port,
  output logic [CNT_W-1:0]    cycle_count,
  output logic                busy,
  output logic                finished,
  output logic                timeout
);

  localparam logic [CNT_W-1:0]  c_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [ADDR_W-1:0] c_ONE     = ADDR_W'(1);
  localparam logic [7:0]        c_SIZE8   = 8'd8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_START    = 3'd2,
    ST_RUN      = 3'd3,
    ST_READ_REQ = 3'd4,
    ST_READ_OUT = 3'd5,
    ST_FINISH   = 3'd6
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_remaining;
  logic [CNT_W-1:0]  r_counter;
  logic              r_req_pending;  // a write is on the slave port
  logic              r_last_beat;    // the pending write carries in_last

  // Only channel 0 and the low read byte are consumed.
  logic w_unused;
  assign w_unused = &{1'b0, bus.Sout_DataRdy[1], bus.Sout_Rdata_ram[DATA_W-1:8]};

  // Accept a new byte only when no write is outstanding, which limits the
  // load rate to one byte every two cycles.
  assign bus.in_ready = (r_state == ST_LOAD) && !r_req_pending;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state             <= ST_IDLE;
      r_wr_ptr            <= '0;
      r_rd_ptr            <= '0;
      r_remaining         <= '0;
      r_counter           <= '0;
      r_req_pending       <= 1'b0;
      r_last_beat         <= 1'b0;
      bus.S_oe_ram        <= 2'b00;
      bus.S_we_ram        <= 2'b00;
      bus.S_addr_ram      <= '0;
      bus.S_Wdata_ram     <= '0;
      bus.S_data_ram_size <= 8'd0;
      bus.out_valid       <= 1'b0;
      bus.out_data        <= 8'd0;
      bus.out_last        <= 1'b0;
      start_port          <= 1'b0;
      cycle_count         <= '0;
      busy                <= 1'b0;
      finished            <= 1'b0;
      timeout             <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (go) begin
            r_wr_ptr      <= load_base;
            r_rd_ptr      <= rd_base;
            r_remaining   <= rd_len;
            r_req_pending <= 1'b0;
            timeout       <= 1'b0;
            busy          <= 1'b1;
            r_state       <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (!r_req_pending) begin
            if (bus.in_valid) begin
              r_req_pending       <= 1'b1;
              r_last_beat         <= bus.in_last;
              bus.S_we_ram        <= 2'b01;
              bus.S_addr_ram      <= r_wr_ptr;
              bus.S_Wdata_ram     <= {{(DATA_W-8){1'b0}}, bus.in_data};
              bus.S_data_ram_size <= c_SIZE8;
            end
          end else if (bus.Sout_DataRdy[0]) begin
            r_req_pending       <= 1'b0;
            bus.S_we_ram        <= 2'b00;
            bus.S_addr_ram      <= '0;
            bus.S_Wdata_ram     <= '0;
            bus.S_data_ram_size <= 8'd0;
            r_wr_ptr            <= r_wr_ptr + c_ONE;
            if (r_last_beat) begin
              start_port <= 1'b1;
              r_counter  <= CNT_W'(1);  // the start cycle counts as cycle 1
              r_state    <= ST_START;
            end
          end
        end

        ST_START: begin
          start_port <= 1'b0;
          r_counter  <= r_counter + CNT_W'(1);
          r_state    <= ST_RUN;
        end

        ST_RUN: begin
          if (done_port) begin
            cycle_count <= r_counter;
            if (r_remaining != '0) begin
              bus.S_oe_ram        <= 2'b01;
              bus.S_addr_ram      <= r_rd_ptr;
              bus.S_data_ram_size <= c_SIZE8;
              r_state             <= ST_READ_REQ;
            end else begin
              finished <= 1'b1;
              r_state  <= ST_FINISH;
            end
          end else if (r_counter >= c_TIMEOUT) begin
            cycle_count <= c_TIMEOUT;
            timeout     <= 1'b1;
            finished    <= 1'b1;
            r_state     <= ST_FINISH;
          end else begin
            r_counter <= r_counter + CNT_W'(1);
          end
        end

        ST_READ_REQ: begin
          if (bus.Sout_DataRdy[0]) begin
            bus.S_oe_ram        <= 2'b00;
            bus.S_addr_ram      <= '0;
            bus.S_data_ram_size <= 8'd0;
            bus.out_data        <= bus.Sout_Rdata_ram[7:0];
            bus.out_last        <= (r_remaining == c_ONE);
            bus.out_valid       <= 1'b1;
            r_state             <= ST_READ_OUT;
          end
        end

        ST_READ_OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            r_rd_ptr      <= r_rd_ptr + c_ONE;
            r_remaining   <= r_remaining - c_ONE;
            if (bus.out_last) begin
              finished <= 1'b1;
              r_state  <= ST_FINISH;
            end else begin
              // Issue the next read directly so the address is valid on the
              // first READ_REQ cycle.
              bus.S_oe_ram        <= 2'b01;
              bus.S_addr_ram      <= r_rd_ptr + c_ONE;
              bus.S_data_ram_size <= c_SIZE8;
              r_state             <= ST_READ_REQ;
            end
          end
        end

        ST_FINISH: begin
          finished <= 1'b0;
          busy     <= 1'b0;
          r_state  <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_main_slave_session_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_slave_session_sequencer
// Purpose  : Directed self-checking bench for main_slave_session_sequencer.
//            Expected slave requests and readback bytes are queued as the
//            stimulus is driven and compared as the DUT produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_main_slave_session_sequencer;
  localparam int AW = 14;
  localparam int DW = 16;
  localparam int CW = 32;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          go = 1'b0;
  logic [AW-1:0] load_base = '0;
  logic [AW-1:0] rd_base = '0;
  logic [AW-1:0] rd_len = '0;
  logic          done_port = 1'b0;
  logic          start_port;
  logic [CW-1:0] cycle_count;
  logic          busy;
  logic          finished;
  logic          timeout;

  main_slave_session_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  main_slave_session_sequencer #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .go          (go),
    .load_base   (load_base),
    .rd_base     (rd_base),
    .rd_len      (rd_len),
    .bus         (bus.master),
    .start_port  (start_port),
    .done_port   (done_port),
    .cycle_count (cycle_count),
    .busy        (busy),
    .finished    (finished),
    .timeout     (timeout)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int n_start  = 0;
  int n_fin    = 0;
  bit slave_en = 1'b1;

  typedef struct { logic is_wr; logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;
  typedef struct { logic [7:0] data; logic last; } out_t;
  req_t exp_req[$];
  out_t exp_out[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus"}, 64'({bus.in_ready, bus.S_oe_ram, bus.S_we_ram, bus.S_addr_ram,
                            bus.S_Wdata_ram, bus.S_data_ram_size}), 64'd0);
    chk({tag, "_stat"}, 64'({start_port, bus.out_valid, bus.out_data, bus.out_last,
                             cycle_count, busy, finished, timeout}), 64'd0);
  endtask

  // RAM slave: checks each new request against the queue, acks it in the
  // following cycle when enabled.
  initial begin : slave_model
    bit            req_seen;
    logic [DW-1:0] rdata;
    req_t          e;
    req_seen = 1'b0;
    rdata    = '0;
    bus.Sout_DataRdy   = 2'b00;
    bus.Sout_Rdata_ram = '0;
    forever begin
      @(negedge clock);
      bus.Sout_DataRdy = 2'b00;
      if (!reset) begin
        req_seen = 1'b0;
        continue;
      end
      if (start_port) n_start++;
      if (finished)   n_fin++;
      if (bus.S_we_ram[0] || bus.S_oe_ram[0]) begin
        if (!req_seen) begin
          req_seen = 1'b1;
          chk("req_upper_ch", 64'({bus.S_we_ram[1], bus.S_oe_ram[1]}), 64'd0);
          chk("req_size", 64'(bus.S_data_ram_size), 64'd8);
          if (exp_req.size() == 0) begin
            chk("req_unexpected", 64'(bus.S_addr_ram), 64'hDEAD_0000);
          end else begin
            e = exp_req.pop_front();
            chk("req_we", 64'(bus.S_we_ram), e.is_wr ? 64'd1 : 64'd0);
            chk("req_oe", 64'(bus.S_oe_ram), e.is_wr ? 64'd0 : 64'd1);
            chk("req_addr", 64'(bus.S_addr_ram), 64'(e.addr));
            if (e.is_wr) chk("req_wdata", 64'(bus.S_Wdata_ram), 64'(e.data));
            else rdata = e.data;
          end
        end
        if (slave_en) begin
          bus.Sout_DataRdy   = 2'b01;
          bus.Sout_Rdata_ram = rdata;
        end
      end else begin
        req_seen = 1'b0;
      end
    end
  end

  task automatic push_wr(input logic [AW-1:0] a, input logic [7:0] d);
    req_t e;
    e.is_wr = 1'b1; e.addr = a; e.data = {8'h00, d};
    exp_req.push_back(e);
  endtask

  task automatic push_rd(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic last);
    req_t e;
    out_t o;
    e.is_wr = 1'b0; e.addr = a; e.data = d;
    exp_req.push_back(e);
    o.data = d[7:0]; o.last = last;
    exp_out.push_back(o);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_session(input logic [AW-1:0] lb, input logic [AW-1:0] rb,
                               input logic [AW-1:0] rl);
    go = 1'b1; load_base = lb; rd_base = rb; rd_len = rl;
    tick();
    go = 1'b0;
    chk("busy_after_go", 64'(busy), 64'd1);
    chk("timeout_cleared_on_go", 64'(timeout), 64'd0);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_last = last;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("wait_in_ready", 64'd0, 64'd1);
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (!start_port && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("wait_start_port", 64'd0, 64'd1);
  endtask

  // Raise done_port in the cycle k cycles after the current one.
  task automatic pulse_done(input int k);
    repeat (k) tick();
    done_port = 1'b1;
    tick();
    done_port = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("wait_idle", 64'd0, 64'd1);
  endtask

  initial begin : stimulus
    out_t o;
    int   n;
    bus.in_valid = 1'b0; bus.in_data = 8'd0; bus.in_last = 1'b0; bus.out_ready = 1'b0;

    // reset state
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b1;
    tick();

    // four-byte load, no readback, done 5 cycles after start
    push_wr(14'h0100, 8'h11); push_wr(14'h0101, 8'h22);
    push_wr(14'h0102, 8'h33); push_wr(14'h0103, 8'h44);
    start_session(14'h0100, 14'h0000, 14'd0);
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0); send_byte(8'h44, 1'b1);
    wait_start();
    pulse_done(5);
    wait_idle();
    chk("t1_cycle_count", 64'(cycle_count), 64'd6);
    chk("t1_timeout", 64'(timeout), 64'd0);
    chk("t1_start_pulses", 64'(n_start), 64'd1);
    chk("t1_finished_pulses", 64'(n_fin), 64'd1);
    chk("t1_writes_done", 64'(exp_req.size()), 64'd0);

    // readback of three bytes with stalled sink
    push_wr(14'h0010, 8'h5A);
    push_rd(14'h0200, 16'hAB12, 1'b0);
    push_rd(14'h0201, 16'hCD34, 1'b0);
    push_rd(14'h0202, 16'hEF56, 1'b1);
    start_session(14'h0010, 14'h0200, 14'd3);
    send_byte(8'h5A, 1'b1);
    wait_start();
    pulse_done(3);
    for (int b = 0; b < 3; b++) begin
      n = 0;
      while (!bus.out_valid && n < 50) begin
        tick();
        n++;
      end
      if (n >= 50) chk("wait_out_valid", 64'd0, 64'd1);
      o = exp_out.pop_front();
      for (int s = 0; s < 3; s++) begin
        chk("rb_stall_valid", 64'(bus.out_valid), 64'd1);
        chk("rb_stall_data", 64'(bus.out_data), 64'(o.data));
        chk("rb_stall_last", 64'(bus.out_last), 64'(o.last));
        tick();
      end
      bus.out_ready = 1'b1;
      chk("rb_data", 64'(bus.out_data), 64'(o.data));
      chk("rb_last", 64'(bus.out_last), 64'(o.last));
      tick();
      bus.out_ready = 1'b0;
    end
    wait_idle();
    chk("t2_cycle_count", 64'(cycle_count), 64'd4);
    chk("t2_finished_pulses", 64'(n_fin), 64'd2);
    chk("t2_reads_done", 64'(exp_req.size()), 64'd0);

    // timeout: done never comes, readback must be skipped
    push_wr(14'h0020, 8'h77);
    start_session(14'h0020, 14'h0300, 14'd2);
    send_byte(8'h77, 1'b1);
    wait_idle();
    chk("t3_timeout", 64'(timeout), 64'd1);
    chk("t3_cycle_count", 64'(cycle_count), 64'd16);
    chk("t3_finished_pulses", 64'(n_fin), 64'd3);
    chk("t3_oe_idle", 64'(bus.S_oe_ram), 64'd0);

    // write address wraps at the top of the address space
    push_wr(14'h3FFF, 8'h0A); push_wr(14'h0000, 8'h0B);
    start_session(14'h3FFF, 14'h0000, 14'd0);
    send_byte(8'h0A, 1'b0); send_byte(8'h0B, 1'b1);
    wait_start();
    pulse_done(1);
    wait_idle();
    chk("t4_cycle_count", 64'(cycle_count), 64'd2);
    chk("t4_writes_done", 64'(exp_req.size()), 64'd0);

    // asynchronous reset while a write is pending
    slave_en = 1'b0;
    push_wr(14'h0055, 8'h99);
    start_session(14'h0055, 14'h0000, 14'd0);
    send_byte(8'h99, 1'b0);
    tick();
    chk("t5_we_pending", 64'(bus.S_we_ram), 64'd1);
    #2 reset = 1'b0;
    #1 chk_all_zero("async_reset");
    tick();
    reset = 1'b1;
    slave_en = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 8'hEE;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t5_in_ready_low", 64'(bus.in_ready), 64'd0);
      chk("t5_no_write", 64'(bus.S_we_ram), 64'd0);
    end
    bus.in_valid = 1'b0;
    chk("t5_idle", 64'(busy), 64'd0);
    chk("t5_queue_empty", 64'(exp_req.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
